mac_matvec_seq: RTL

Parametrised, sequential N×N matrix-by-vector multiply-accumulate engine: computes c = A·b by streaming one column of A plus the matching element of b per accepted beat into N parallel MAC lanes. Valid/ready handshakes on input and output. Selectable signed/unsigned arithmetic. Full-precision, non-overflowing accumulators. Sits in the matrix datapath as the successor to the fixed 3×3, 8-bit, single-cycle matrix-vector MAC.

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_lane.sv | 44 ++++
 rtl/mac_matvec_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the matrix-vector MAC engine and its consumers.
package mac_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  // Ceiling log2 with clog2(1) = 0.
  function automatic int unsigned clog2_u(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width that cannot overflow for n products of two dw-bit operands.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + clog2_u(n);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One row lane: DWxDW multiply feeding a full-precision AW-bit accumulator.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 18,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);

  logic [AW-1:0] a_x;
  logic [AW-1:0] b_x;
  logic [AW-1:0] prod;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] acc_q;

  // Extend operands to AW first; the low AW bits of the product are then
  // exact for both signed and unsigned operands since AW >= 2*DW.
  always_comb begin
    a_x   = SIGNED ? {{(AW-DW){a[DW-1]}}, a} : {{(AW-DW){1'b0}}, a};
    b_x   = SIGNED ? {{(AW-DW){b[DW-1]}}, b} : {{(AW-DW){1'b0}}, b};
    prod  = a_x * b_x;
    acc_d = load ? prod : (acc_q + prod);
  end

  // Accumulator register: overwrite on the first column, add on the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_matvec_seq.sv
// Sequential NxN matrix-vector MAC: one column of A and one element of b per beat.
module mac_matvec_seq
  import mac_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 8,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned AW    = acc_width(DW, N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [DW-1:0]   b_elem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] c
);

  localparam int unsigned     CW       = (N > 1) ? clog2_u(N) : 1;
  localparam logic [CW-1:0]   COL_LAST = CW'(N - 1);
  localparam logic [CW-1:0]   COL_ONE  = CW'(1);

  state_e        state_q;
  logic [CW-1:0] col_q;
  logic          beat;
  logic          first;

  // A beat in the same cycle as clear is dropped.
  assign beat      = in_valid && (state_q == ACC) && !clear;
  assign first     = (col_q == '0);
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);

  // Control FSM and column counter; DONE always returns to ACC through one bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC;
      col_q   <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (clear) begin
            col_q <= '0;
          end else if (in_valid) begin
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= DONE;
            end else begin
              col_q <= col_q + COL_ONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= ACC;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mac_lane #(
      .DW     (DW),
      .AW     (AW),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (beat),
      .load    (first),
      .a       (a_col[i*DW +: DW]),
      .b       (b_elem),
      .acc     (c[i*AW +: AW])
    );
  end

endmodule
